// File: rtl/cpu_run_monitor_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mon_pkg
// Shared types for the 6502 run monitor: the controller state and the cause
// that ended a run. Imported by cpu_run_monitor.
// ---------------------------------------------------------------------------
package cpu_mon_pkg;

    typedef enum logic [1:0] {
        MON_RESET,
        MON_RUN,
        MON_DONE
    } mon_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_TRAP,
        CAUSE_TIMEOUT,
        CAUSE_MBOX
    } mon_cause_t;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor_if
// CPU bus as seen by the run monitor.
//   addr  ADDR_W  CPU bus address (the PC when sync is high)
//   dout  DATA_W  CPU write data
//   we    1       CPU write strobe
//   sync  1       opcode-fetch cycle
// Modports: master (CPU side, drives the bus), slave (monitor, observes it).
// ---------------------------------------------------------------------------
interface cpu_run_monitor_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              we;
    logic              sync;

    modport master (output addr, output dout, output we, output sync);
    modport slave  (input  addr, input  dout, input  we, input  sync);

endinterface

// File: rtl/cpu_run_monitor_trap_detect.sv
// ---------------------------------------------------------------------------
// cpu_trap_detect
// Watches opcode fetches and flags a trap loop: TRAP_REPEAT consecutive
// fetches from the same address.
//   clk, rst    clock, synchronous active-high reset
//   en          detector active (monitor is in RUN)
//   sync, addr  opcode-fetch strobe and fetch address
//   trap        combinational pulse in the cycle the repeat count is reached
//   last_fetch  most recent fetch address, including this cycle's fetch
// ---------------------------------------------------------------------------
module cpu_trap_detect #(
    parameter int ADDR_W      = 16,
    parameter int TRAP_REPEAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic [ADDR_W-1:0] addr,
    output logic              trap,
    output logic [ADDR_W-1:0] last_fetch
);

    localparam int RPT_W = $clog2(TRAP_REPEAT + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(TRAP_REPEAT);

    logic [RPT_W-1:0]  rpt_q;
    logic [RPT_W-1:0]  rpt_d;
    logic [ADDR_W-1:0] last_q;

    // A fetch from the same address as the previous fetch extends the run of
    // repeats; any other address starts a new run of length one. The count
    // saturates so a core parked in the loop never wraps back below the limit.
    // The last address starts at zero with a zero count, so a first fetch at
    // address zero still counts as one.
    always_comb begin
        rpt_d      = rpt_q;
        trap       = 1'b0;
        last_fetch = last_q;
        if (en && sync) begin
            last_fetch = addr;
            if (addr == last_q) begin
                rpt_d = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + 1'b1;
            end else begin
                rpt_d = RPT_W'(1);
            end
            trap = (rpt_d == RPT_MAX);
        end
    end

    // History only moves on fetches while enabled; everything else leaves it
    // untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q  <= '0;
            last_q <= '0;
        end else if (en && sync) begin
            rpt_q  <= rpt_d;
            last_q <= addr;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
// Run controller for the 6502 core: holds the core in reset for RST_CYCLES
// cycles, counts run cycles, and ends the run on a trap loop, a timeout or
// (optionally) a mailbox write, reporting a pass/fail verdict.
// Optional feature macro: RUN_MONITOR_MAILBOX_EN (mailbox write ends the run).
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           CPU bus (slave modport of cpu_run_monitor_if)
//   o_cpu_rst     reset to core (high in RESET and DONE)
//   o_done        run finished, sticky until i_rst
//   o_pass        verdict, valid when o_done
//   o_timeout     run ended by timeout
//   o_trap_pc     PC at which the run ended
//   o_cycles      RUN cycles elapsed, frozen at done
//   o_code        mailbox code (0 when the mailbox is disabled)
// ---------------------------------------------------------------------------
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 4,
    parameter logic [CNT_W-1:0]  TIMEOUT     = CNT_W'(100000),
    parameter int                TRAP_REPEAT = 3,
    parameter logic [ADDR_W-1:0] PASS_ADDR   = ADDR_W'(16'h3469),
    parameter logic [ADDR_W-1:0] MBOX_ADDR   = ADDR_W'(16'h0200)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cpu_run_monitor_if.slave  bus,
    output logic              o_cpu_rst,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [ADDR_W-1:0] o_trap_pc,
    output logic [CNT_W-1:0]  o_cycles,
    output logic [DATA_W-1:0] o_code
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - 1'b1;

    mon_state_t        state_q, state_d;
    mon_cause_t        cause_q, cause_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] trap_pc_q, trap_pc_d;
    logic [DATA_W-1:0] code_q, code_d;

    logic              run_en;
    logic              trap_hit;
    logic              timeout_hit;
    logic              mbox_hit;
    logic [DATA_W-1:0] mbox_code;
    logic [ADDR_W-1:0] last_fetch;

    assign run_en      = (state_q == MON_RUN);
    assign timeout_hit = (cycles_q == CNT_LAST);

`ifdef RUN_MONITOR_MAILBOX_EN
    assign mbox_hit  = bus.we && (bus.addr == MBOX_ADDR);
    assign mbox_code = bus.dout;
`else
    logic unused_mbox;
    assign unused_mbox = ^{bus.dout, bus.we, MBOX_ADDR};
    assign mbox_hit    = 1'b0;
    assign mbox_code   = '0;
`endif

    cpu_trap_detect #(
        .ADDR_W     (ADDR_W),
        .TRAP_REPEAT(TRAP_REPEAT)
    ) u_trap (
        .clk       (i_clk),
        .rst       (i_rst),
        .en        (run_en),
        .sync      (bus.sync),
        .addr      (bus.addr),
        .trap      (trap_hit),
        .last_fetch(last_fetch)
    );

    // Next-state and verdict logic. RESET counts out the core reset window,
    // RUN counts cycles and latches exactly one end cause (mailbox beats trap
    // beats timeout), DONE freezes everything until the next i_rst.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        rst_cnt_d = rst_cnt_q;
        cycles_d  = cycles_q;
        pass_d    = pass_q;
        trap_pc_d = trap_pc_q;
        code_d    = code_q;
        case (state_q)
            MON_RESET: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = MON_RUN;
                end
            end
            MON_RUN: begin
                cycles_d = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
                if (mbox_hit) begin
                    state_d   = MON_DONE;
                    cause_d   = CAUSE_MBOX;
                    code_d    = mbox_code;
                    pass_d    = (mbox_code == '0);
                    trap_pc_d = last_fetch;
                end else if (trap_hit) begin
                    state_d   = MON_DONE;
                    cause_d   = CAUSE_TRAP;
                    pass_d    = (bus.addr == PASS_ADDR);
                    trap_pc_d = bus.addr;
                end else if (timeout_hit) begin
                    state_d   = MON_DONE;
                    cause_d   = CAUSE_TIMEOUT;
                    pass_d    = 1'b0;
                    trap_pc_d = last_fetch;
                end
            end
            MON_DONE: begin
                state_d = MON_DONE;
            end
            default: begin
                state_d = MON_RESET;
            end
        endcase
    end

    // State and verdict registers; i_rst discards any verdict from the
    // previous run and restarts the reset window from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= MON_RESET;
            cause_q   <= CAUSE_NONE;
            rst_cnt_q <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            trap_pc_q <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            rst_cnt_q <= rst_cnt_d;
            cycles_q  <= cycles_d;
            pass_q    <= pass_d;
            trap_pc_q <= trap_pc_d;
            code_q    <= code_d;
        end
    end

    // The core is held in reset everywhere except RUN, so it sits quiescent
    // once a verdict has been reached.
    assign o_cpu_rst = (state_q != MON_RUN);
    assign o_done    = (state_q == MON_DONE);
    assign o_pass    = pass_q;
    assign o_timeout = (cause_q == CAUSE_TIMEOUT);
    assign o_trap_pc = trap_pc_q;
    assign o_cycles  = cycles_q;
    assign o_code    = code_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
// Self-checking bench for cpu_run_monitor with TIMEOUT=50. A fetch-history
// model predicts every output each cycle; directed scenarios add literal
// expectations. Mailbox scenarios follow RUN_MONITOR_MAILBOX_EN.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 4;
    localparam int TIMEOUT     = 50;
    localparam int TRAP_REPEAT = 3;
    localparam logic [15:0] PASS_ADDR = 16'h3469;
    localparam logic [15:0] MBOX_ADDR = 16'h0200;
`ifdef RUN_MONITOR_MAILBOX_EN
    localparam bit MBOX_EN = 1'b1;
`else
    localparam bit MBOX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        check_en = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic        o_cpu_rst;
    logic        o_done;
    logic        o_pass;
    logic        o_timeout;
    logic [15:0] o_trap_pc;
    logic [31:0] o_cycles;
    logic [7:0]  o_code;

    cpu_run_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cpu_run_monitor #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (CNT_W'(TIMEOUT)),
        .TRAP_REPEAT(TRAP_REPEAT),
        .PASS_ADDR  (PASS_ADDR),
        .MBOX_ADDR  (MBOX_ADDR)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .o_cpu_rst(o_cpu_rst),
        .o_done   (o_done),
        .o_pass   (o_pass),
        .o_timeout(o_timeout),
        .o_trap_pc(o_trap_pc),
        .o_cycles (o_cycles),
        .o_code   (o_code)
    );

    always #5 clk = ~clk;

    // Reference model: tracks how far past reset release we are, the recent
    // fetch history and the run cycle count, and decides the verdict from
    // those directly.
    int          m_rel = 0;
    bit          m_done = 1'b0;
    bit          m_pass = 1'b0;
    bit          m_timeout = 1'b0;
    logic [15:0] m_pc = '0;
    logic [31:0] m_cycles = '0;
    logic [7:0]  m_code = '0;
    logic [15:0] hist[$];

    always @(posedge clk) begin
        bit          mbox_w;
        bit          trap_w;
        bit          tmo_w;
        logic [15:0] last_w;
        if (rst) begin
            m_rel     = 0;
            m_done    = 1'b0;
            m_pass    = 1'b0;
            m_timeout = 1'b0;
            m_pc      = '0;
            m_cycles  = '0;
            m_code    = '0;
            hist.delete();
        end else if (!m_done) begin
            if (m_rel < RST_CYCLES) begin
                m_rel++;
            end else begin
                if (bus.sync) begin
                    hist.push_back(bus.addr);
                    if (hist.size() > TRAP_REPEAT) void'(hist.pop_front());
                end
                last_w = (hist.size() > 0) ? hist[$] : 16'h0000;
                mbox_w = MBOX_EN && bus.we && (bus.addr == MBOX_ADDR);
                trap_w = bus.sync && (hist.size() == TRAP_REPEAT);
                for (int i = 0; i < hist.size(); i++) begin
                    if (hist[i] !== bus.addr) trap_w = 1'b0;
                end
                tmo_w = (m_cycles == 32'(TIMEOUT - 1));
                m_cycles = m_cycles + 1;
                if (mbox_w) begin
                    m_done = 1'b1;
                    m_code = bus.dout;
                    m_pass = (bus.dout == 8'h00);
                    m_pc   = last_w;
                end else if (trap_w) begin
                    m_done = 1'b1;
                    m_pass = (bus.addr == PASS_ADDR);
                    m_pc   = bus.addr;
                end else if (tmo_w) begin
                    m_done    = 1'b1;
                    m_timeout = 1'b1;
                    m_pass    = 1'b0;
                    m_pc      = last_w;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_assert++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model, on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cpu_rst", 32'(o_cpu_rst), 32'(!((m_rel == RST_CYCLES) && !m_done)));
            checkOutput("done", 32'(o_done), 32'(m_done));
            checkOutput("pass", 32'(o_pass), 32'(m_pass));
            checkOutput("timeout", 32'(o_timeout), 32'(m_timeout));
            checkOutput("trap_pc", 32'(o_trap_pc), 32'(m_pc));
            checkOutput("cycles", o_cycles, m_cycles);
            checkOutput("code", 32'(o_code), 32'(m_code));
        end
    end

    task automatic applyStimulus(input logic s, input logic [15:0] a,
                                 input logic w, input logic [7:0] d);
        bus.sync = s;
        bus.addr = a;
        bus.we   = w;
        bus.dout = d;
        @(posedge clk);
        #1;
    endtask

    // One-cycle i_rst, then count how long the core reset stays high. The bus
    // carries a repeated fetch and a mailbox write throughout, which must be
    // ignored outside RUN.
    task automatic resetAndRelease();
        int n;
        rst      = 1'b1;
        bus.sync = 1'b1;
        bus.addr = MBOX_ADDR;
        bus.we   = 1'b1;
        bus.dout = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;
        checkOutput("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_pass", 32'(o_pass), 32'd0);
        checkOutput("rst_timeout", 32'(o_timeout), 32'd0);
        checkOutput("rst_trap_pc", 32'(o_trap_pc), 32'd0);
        checkOutput("rst_cycles", o_cycles, 32'd0);
        checkOutput("rst_code", 32'(o_code), 32'd0);
        n = 0;
        while (o_cpu_rst === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("rst_window", 32'(n), 32'd4);
        checkOutput("run_start_cycles", o_cycles, 32'd0);
        bus.sync = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 16'h0000;
    endtask

    initial begin
        bus.sync = 1'b0;
        bus.addr = '0;
        bus.we   = 1'b0;
        bus.dout = '0;
        @(posedge clk);
        #1;

        // Pass trap at PASS_ADDR after two ordinary fetches.
        resetAndRelease();
        applyStimulus(1'b1, 16'h1000, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h1001, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h3469, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h3469, 1'b0, 8'h00);
        checkOutput("pass_not_yet", 32'(o_done), 32'd0);
        applyStimulus(1'b1, 16'h3469, 1'b0, 8'h00);
        checkOutput("pass_done", 32'(o_done), 32'd1);
        checkOutput("pass_verdict", 32'(o_pass), 32'd1);
        checkOutput("pass_pc", 32'(o_trap_pc), 32'h3469);
        checkOutput("pass_cycles", o_cycles, 32'd5);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h7777, 1'b0, 8'h00);
        checkOutput("pass_frozen_cycles", o_cycles, 32'd5);
        checkOutput("pass_frozen_cpu_rst", 32'(o_cpu_rst), 32'd1);

        // Fail trap at 0x0400 with non-fetch cycles in between.
        resetAndRelease();
        applyStimulus(1'b1, 16'h0400, 1'b0, 8'h00);
        applyStimulus(1'b0, 16'h0401, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h0400, 1'b0, 8'h00);
        applyStimulus(1'b0, 16'h0401, 1'b0, 8'h00);
        applyStimulus(1'b1, 16'h0400, 1'b0, 8'h00);
        checkOutput("fail_done", 32'(o_done), 32'd1);
        checkOutput("fail_verdict", 32'(o_pass), 32'd0);
        checkOutput("fail_pc", 32'(o_trap_pc), 32'h0400);
        checkOutput("fail_cycles", o_cycles, 32'd5);

        // Timeout with never-repeating fetches.
        resetAndRelease();
        for (int i = 0; i < 60; i++) begin
            if (o_done) break;
            applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 8'h00);
        end
        checkOutput("tmo_done", 32'(o_done), 32'd1);
        checkOutput("tmo_flag", 32'(o_timeout), 32'd1);
        checkOutput("tmo_cycles", o_cycles, 32'd50);
        checkOutput("tmo_verdict", 32'(o_pass), 32'd0);
        checkOutput("tmo_pc", 32'(o_trap_pc), 32'h2031);

        // Trap completing on the timeout cycle: the trap is recorded.
        resetAndRelease();
        for (int i = 0; i < 47; i++) applyStimulus(1'b1, 16'h5000 + 16'(i), 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0ABC, 1'b0, 8'h00);
        checkOutput("prio_done", 32'(o_done), 32'd1);
        checkOutput("prio_timeout", 32'(o_timeout), 32'd0);
        checkOutput("prio_pc", 32'(o_trap_pc), 32'h0ABC);
        checkOutput("prio_cycles", o_cycles, 32'd50);

`ifdef RUN_MONITOR_MAILBOX_EN
        // Mailbox: zero code passes, non-zero fails.
        resetAndRelease();
        applyStimulus(1'b1, 16'h1234, 1'b0, 8'h00);
        applyStimulus(1'b0, MBOX_ADDR, 1'b1, 8'h00);
        checkOutput("mbox0_done", 32'(o_done), 32'd1);
        checkOutput("mbox0_pass", 32'(o_pass), 32'd1);
        checkOutput("mbox0_code", 32'(o_code), 32'd0);
        checkOutput("mbox0_pc", 32'(o_trap_pc), 32'h1234);
        resetAndRelease();
        applyStimulus(1'b1, 16'h1234, 1'b0, 8'h00);
        applyStimulus(1'b0, MBOX_ADDR, 1'b1, 8'h2A);
        checkOutput("mbox2a_done", 32'(o_done), 32'd1);
        checkOutput("mbox2a_pass", 32'(o_pass), 32'd0);
        checkOutput("mbox2a_code", 32'(o_code), 32'h2A);
        checkOutput("mbox2a_cycles", o_cycles, 32'd2);
`else
        // Mailbox absent: a write to MBOX_ADDR must not end the run.
        resetAndRelease();
        applyStimulus(1'b1, 16'h1234, 1'b0, 8'h00);
        applyStimulus(1'b0, MBOX_ADDR, 1'b1, 8'h2A);
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00);
        checkOutput("nombox_done", 32'(o_done), 32'd0);
        checkOutput("nombox_code", 32'(o_code), 32'd0);
        checkOutput("nombox_cycles", o_cycles, 32'd3);
`endif

        // Reset mid-run after 20 cycles, then a fresh run ending in a pass.
        resetAndRelease();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0, 8'h00);
        checkOutput("mid_cycles", o_cycles, 32'd20);
        resetAndRelease();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, PASS_ADDR, 1'b0, 8'h00);
        checkOutput("rerun_done", 32'(o_done), 32'd1);
        checkOutput("rerun_pass", 32'(o_pass), 32'd1);
        checkOutput("rerun_cycles", o_cycles, 32'd3);

        // Reset while DONE clears the verdict (checked inside the task).
        resetAndRelease();
        applyStimulus(1'b0, 16'h0000, 1'b0, 8'h00);
        checkOutput("post_done_cycles", o_cycles, 32'd1);

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
